id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage for the five-stage core. It latches decoded operands and control from the decode (ID) stage and drives the A, B and ALUOp inputs of the ALU through result-forwarding muxes. It also detects load-use hazards and requests a one-cycle freeze of fetch/decode, inserting a bubble into EX. It sits between the register file / decoder and the ALU.

---
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_stage.sv | 130 +++++++++++++
 tb/tb_id_ex_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the EX/MEM and MEM/WB writers, and the ID/EX stage.
// The master drives decode fields and writer buses; the slave (id_ex_stage) drives ALU operands.
interface id_ex_stage_if;
    logic        ID_Valid;
    logic [31:0] ID_RD1;
    logic [31:0] ID_RD2;
    logic [31:0] ID_Imm32;
    logic        ID_BSel;
    logic [2:0]  ID_ALUOp;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic [4:0]  ID_WAddr;
    logic        ID_MemRead;
    logic        Flush;
    logic        MEM_WE;
    logic [4:0]  MEM_WAddr;
    logic [31:0] MEM_Result;
    logic        WB_WE;
    logic [4:0]  WB_WAddr;
    logic [31:0] WB_WD;
    logic        Stall;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic        EX_Valid;
    logic [4:0]  EX_WAddr;
    logic        EX_MemRead;

    modport master (
        output ID_Valid, ID_RD1, ID_RD2, ID_Imm32, ID_BSel, ID_ALUOp, ID_Rs, ID_Rt,
               ID_WAddr, ID_MemRead, Flush, MEM_WE, MEM_WAddr, MEM_Result,
               WB_WE, WB_WAddr, WB_WD,
        input  Stall, A, B, ALUOp, EX_Valid, EX_WAddr, EX_MemRead
    );

    modport slave (
        input  ID_Valid, ID_RD1, ID_RD2, ID_Imm32, ID_BSel, ID_ALUOp, ID_Rs, ID_Rt,
               ID_WAddr, ID_MemRead, Flush, MEM_WE, MEM_WAddr, MEM_Result,
               WB_WE, WB_WAddr, WB_WD,
        output Stall, A, B, ALUOp, EX_Valid, EX_WAddr, EX_MemRead
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: latches decoded operands, forwards EX/MEM and MEM/WB results, raises Stall on hazards.
// Define ID_EX_FWD_EN for forwarding (load-use stall only); without it the stage stalls on any in-flight producer.
module id_ex_stage (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    logic        valid_q,   valid_d;
    logic [31:0] rd1_q,     rd1_d;
    logic [31:0] rd2_q,     rd2_d;
    logic [31:0] imm_q,     imm_d;
    logic        bsel_q,    bsel_d;
    logic [2:0]  aluop_q,   aluop_d;
    logic [4:0]  rs_q,      rs_d;
    logic [4:0]  rt_q,      rt_d;
    logic [4:0]  waddr_q,   waddr_d;
    logic        memread_q, memread_d;

    logic        stall;
    logic        ex_hit;
    logic [31:0] a_val;
    logic [31:0] rt_val;

    // Destination of the instruction in EX matches a source of the instruction in ID.
    assign ex_hit = (waddr_q != 5'd0) &&
                    ((waddr_q == bus.ID_Rs) || (waddr_q == bus.ID_Rt));

`ifdef ID_EX_FWD_EN
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] latched,
        input logic        mem_we,
        input logic [4:0]  mem_waddr,
        input logic [31:0] mem_result,
        input logic        wb_we,
        input logic [4:0]  wb_waddr,
        input logic [31:0] wb_wd
    );
        if (src != 5'd0 && mem_we && mem_waddr == src)
            return mem_result;
        else if (src != 5'd0 && wb_we && wb_waddr == src)
            return wb_wd;
        else
            return latched;
    endfunction

    assign stall  = ~reset & ~bus.Flush & bus.ID_Valid & valid_q & memread_q & ex_hit;
    assign a_val  = fwd_sel(rs_q, rd1_q, bus.MEM_WE, bus.MEM_WAddr, bus.MEM_Result,
                            bus.WB_WE, bus.WB_WAddr, bus.WB_WD);
    assign rt_val = fwd_sel(rt_q, rd2_q, bus.MEM_WE, bus.MEM_WAddr, bus.MEM_Result,
                            bus.WB_WE, bus.WB_WAddr, bus.WB_WD);
`else
    logic mem_hit;

    assign mem_hit = bus.MEM_WE && (bus.MEM_WAddr != 5'd0) &&
                     ((bus.MEM_WAddr == bus.ID_Rs) || (bus.MEM_WAddr == bus.ID_Rt));
    // Reset gating matters here: a live MEM writer must not hold Stall high during reset.
    assign stall  = ~reset & ~bus.Flush & bus.ID_Valid & ((valid_q & ex_hit) | mem_hit);
    assign a_val  = rd1_q;
    assign rt_val = rd2_q;
`endif

    // NOTE: every next-state signal gets a default (hold) first so no latch is inferred.
    always_comb begin
        valid_d   = valid_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        imm_d     = imm_q;
        bsel_d    = bsel_q;
        aluop_d   = aluop_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        waddr_d   = waddr_q;
        memread_d = memread_q;
        if (bus.Flush || stall) begin
            // Bubble: only control is cleared, data registers keep their contents.
            valid_d   = 1'b0;
            waddr_d   = 5'd0;
            memread_d = 1'b0;
            aluop_d   = 3'd0;
            bsel_d    = 1'b0;
        end else begin
            valid_d   = bus.ID_Valid;
            rd1_d     = bus.ID_RD1;
            rd2_d     = bus.ID_RD2;
            imm_d     = bus.ID_Imm32;
            bsel_d    = bus.ID_BSel;
            aluop_d   = bus.ID_ALUOp;
            rs_d      = bus.ID_Rs;
            rt_d      = bus.ID_Rt;
            waddr_d   = bus.ID_WAddr;
            memread_d = bus.ID_MemRead;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rd1_q     <= 32'd0;
            rd2_q     <= 32'd0;
            imm_q     <= 32'd0;
            bsel_q    <= 1'b0;
            aluop_q   <= 3'd0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            waddr_q   <= 5'd0;
            memread_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            imm_q     <= imm_d;
            bsel_q    <= bsel_d;
            aluop_q   <= aluop_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            waddr_q   <= waddr_d;
            memread_q <= memread_d;
        end
    end

    assign bus.Stall      = stall;
    assign bus.A          = a_val;
    assign bus.B          = bsel_q ? imm_q : rt_val;
    assign bus.ALUOp      = aluop_q;
    assign bus.EX_Valid   = valid_q;
    assign bus.EX_WAddr   = waddr_q;
    assign bus.EX_MemRead = memread_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model of the stage, EX-side results queued at drive time and checked after the edge.
// Follows the same ID_EX_FWD_EN build option as the design.
module tb_id_ex_stage;
    typedef struct {
        logic        id_valid;
        logic [31:0] rd1, rd2, imm;
        logic        bsel;
        logic [2:0]  aluop;
        logic [4:0]  rs, rt, waddr;
        logic        memread, flush;
        logic        mem_we;
        logic [4:0]  mem_waddr;
        logic [31:0] mem_result;
        logic        wb_we;
        logic [4:0]  wb_waddr;
        logic [31:0] wb_wd;
    } stim_t;

    typedef struct {
        logic       valid;
        logic [4:0] waddr;
        logic       memread;
        logic [2:0] aluop;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    stim_t s;
    exp_t  exp_q[$];

    // Reference state of the stage
    logic        m_valid, m_bsel, m_memread;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [2:0]  m_aluop;
    logic [4:0]  m_rs, m_rt, m_waddr;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_stim();
        s = '{id_valid: 1'b0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0, bsel: 1'b0, aluop: 3'd0,
              rs: 5'd0, rt: 5'd0, waddr: 5'd0, memread: 1'b0, flush: 1'b0,
              mem_we: 1'b0, mem_waddr: 5'd0, mem_result: 32'd0,
              wb_we: 1'b0, wb_waddr: 5'd0, wb_wd: 32'd0};
    endtask

    task automatic drive();
        bus.ID_Valid   = s.id_valid;
        bus.ID_RD1     = s.rd1;
        bus.ID_RD2     = s.rd2;
        bus.ID_Imm32   = s.imm;
        bus.ID_BSel    = s.bsel;
        bus.ID_ALUOp   = s.aluop;
        bus.ID_Rs      = s.rs;
        bus.ID_Rt      = s.rt;
        bus.ID_WAddr   = s.waddr;
        bus.ID_MemRead = s.memread;
        bus.Flush      = s.flush;
        bus.MEM_WE     = s.mem_we;
        bus.MEM_WAddr  = s.mem_waddr;
        bus.MEM_Result = s.mem_result;
        bus.WB_WE      = s.wb_we;
        bus.WB_WAddr   = s.wb_waddr;
        bus.WB_WD      = s.wb_wd;
    endtask

    task automatic model_reset();
        m_valid = 0; m_bsel = 0; m_memread = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_aluop = 0; m_rs = 0; m_rt = 0; m_waddr = 0;
    endtask

    function automatic logic model_stall();
        logic uses_ex;
        logic uses_mem;
        uses_ex  = (m_waddr != 0) && (m_waddr == s.rs || m_waddr == s.rt);
        uses_mem = s.mem_we && (s.mem_waddr != 0) && (s.mem_waddr == s.rs || s.mem_waddr == s.rt);
`ifdef ID_EX_FWD_EN
        uses_mem = 1'b0;
        return !s.flush && s.id_valid && m_valid && m_memread && uses_ex;
`else
        return !s.flush && s.id_valid && ((m_valid && uses_ex) || uses_mem);
`endif
    endfunction

    function automatic logic [31:0] model_src(input logic [4:0] r, input logic [31:0] held);
`ifdef ID_EX_FWD_EN
        if (r == 0) return held;
        if (s.mem_we && s.mem_waddr == r) return s.mem_result;
        if (s.wb_we && s.wb_waddr == r) return s.wb_wd;
`endif
        return held;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "/stall"},   bus.Stall, 0);
        check({tag, "/a"},       bus.A, 0);
        check({tag, "/b"},       bus.B, 0);
        check({tag, "/aluop"},   bus.ALUOp, 0);
        check({tag, "/valid"},   bus.EX_Valid, 0);
        check({tag, "/waddr"},   bus.EX_WAddr, 0);
        check({tag, "/memread"}, bus.EX_MemRead, 0);
    endtask

    // One clock: drive at negedge, check combinational outputs, then check latched outputs after the edge.
    task automatic step(input string tag);
        logic st;
        exp_t e;
        @(negedge clk);
        drive();
        #1;
        st = model_stall();
        check({tag, "/stall"}, bus.Stall, st);
        check({tag, "/a"},     bus.A, model_src(m_rs, m_rd1));
        check({tag, "/b"},     bus.B, m_bsel ? m_imm : model_src(m_rt, m_rd2));
        check({tag, "/aluop"}, bus.ALUOp, m_aluop);
        if (s.flush || st) begin
            m_valid = 0; m_waddr = 0; m_memread = 0; m_aluop = 0; m_bsel = 0;
        end else begin
            m_valid = s.id_valid; m_rd1 = s.rd1; m_rd2 = s.rd2; m_imm = s.imm;
            m_bsel = s.bsel; m_aluop = s.aluop; m_rs = s.rs; m_rt = s.rt;
            m_waddr = s.waddr; m_memread = s.memread;
        end
        exp_q.push_back('{valid: m_valid, waddr: m_waddr, memread: m_memread, aluop: m_aluop});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "/queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "/ex_valid"},   bus.EX_Valid, e.valid);
            check({tag, "/ex_waddr"},   bus.EX_WAddr, e.waddr);
            check({tag, "/ex_memread"}, bus.EX_MemRead, e.memread);
            check({tag, "/ex_aluop"},   bus.ALUOp, e.aluop);
        end
    endtask

    task automatic set_load9();
        clear_stim();
        s.id_valid = 1; s.memread = 1; s.waddr = 9; s.rs = 1; s.rt = 2; s.aluop = 3'd4;
    endtask

    task automatic set_use9();
        clear_stim();
        s.id_valid = 1; s.rs = 1; s.rt = 9; s.rd1 = 32'h10; s.rd2 = 32'h55;
        s.waddr = 10; s.aluop = 3'd3;
    endtask

    initial begin
        model_reset();
        clear_stim();
        // Reset held while decode presents a live instruction and MEM shows a writer
        s.id_valid = 1; s.rd1 = 32'h1234; s.rs = 3; s.waddr = 6; s.aluop = 3'd5;
        s.mem_we = 1; s.mem_waddr = 3;
        reset = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        @(posedge clk);
        #1 reset = 1'b0;
        step("rst_first");

        clear_stim();
        s.id_valid = 1; s.rd1 = 5; s.rd2 = 7; s.aluop = 3'b001; s.rs = 1; s.rt = 2; s.waddr = 4;
        step("plain");
        clear_stim();
        s.id_valid = 1; s.bsel = 1; s.imm = 32'hFFFF_FFFC; s.aluop = 3'd2;
        s.rs = 5; s.rt = 6; s.waddr = 7; s.rd2 = 32'h77;
        step("imm_load");
        clear_stim();
        step("imm_chk");

        clear_stim();
        s.id_valid = 1; s.rs = 8; s.rd1 = 32'h99;
        step("fwd_setup");
        s.id_valid = 0;
        s.mem_we = 1; s.mem_waddr = 8; s.mem_result = 32'h11;
        s.wb_we = 1; s.wb_waddr = 8; s.wb_wd = 32'h22;
        step("fwd_both");
        s.mem_we = 0;
        s.rs = 0; s.rd1 = 32'h33;
        step("fwd_wb");
        s.mem_we = 1; s.mem_waddr = 0; s.wb_waddr = 0;
        step("fwd_zero");

        set_load9();
        step("lw");
        set_use9();
        step("use");
        s.mem_we = 1; s.mem_waddr = 9; s.mem_result = 32'hAA;
        step("use_hold");
        s.mem_we = 0; s.wb_we = 1; s.wb_waddr = 9; s.wb_wd = 32'hAA; s.rd2 = 32'hAA;
        step("use_wb");
        clear_stim();
        step("use_done");

        set_load9();
        step("lw2");
        set_use9();
        s.flush = 1;
        step("flush_use");
        clear_stim();
        step("flush_done");

        clear_stim();
        s.id_valid = 1; s.waddr = 3; s.rs = 1; s.rt = 2; s.rd1 = 32'h1; s.rd2 = 32'h2;
        step("addu");
        clear_stim();
        s.id_valid = 1; s.rs = 3; s.rt = 4; s.waddr = 5; s.rd1 = 32'h300;
        step("rd3_ex");
        s.mem_we = 1; s.mem_waddr = 3; s.mem_result = 32'h333;
        step("rd3_mem");
        s.mem_we = 0; s.wb_we = 1; s.wb_waddr = 3; s.wb_wd = 32'h333; s.rd1 = 32'h333;
        step("rd3_wb");

        set_load9();
        step("lw3");
        set_use9();
        @(negedge clk);
        drive();
        #1 check("mid_rst/stall_before", bus.Stall, 1);
        #2 reset = 1'b1;
        #1 check_zero("mid_rst");
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        step("post_rst");
        clear_stim();
        step("idle");

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
